// File: rtl/reorder_pkg.sv
// reorder_pkg: shared types and helpers for the memory-op reorder slot
// controller.
//   fu_t            - functional-unit code. It uses the same numbering as the
//                     core's issue-stage encoding.
//   reorder_state_e - controller states: IDLE, HOLD and DRAIN.
//   is_mem_op()     - true for a LOAD or STORE.
//   is_barrier()    - true for any control-flow or CSR instruction. No younger
//                     op may overtake a parked memory op across one of these.
package reorder_pkg;

  localparam int unsigned FU_W = 4;

  typedef enum logic [FU_W-1:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6,
    FPU       = 4'd7,
    FPU_VEC   = 4'd8,
    CVXIF     = 4'd9,
    ACCEL     = 4'd10
  } fu_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } reorder_state_e;

  function automatic logic is_mem_op(fu_t fu);
    return (fu == LOAD) || (fu == STORE);
  endfunction

  function automatic logic is_barrier(fu_t fu, logic ctrl_flow);
    return ctrl_flow || (fu == CTRL_FLOW) || (fu == CSR);
  endfunction

endpackage

// File: rtl/reorder_perf_cnt.sv
// reorder_perf_cnt: a CNT_W-bit event counter that saturates at all-ones.
// Reset clears it. It is not cleared in any other way.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   inc_i  - count one event this cycle
//   cnt_o  - current count
module reorder_perf_cnt
  import reorder_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reorder_ctrl.sv
// reorder_ctrl: sequencing controller for the issue-stage memory-op reorder
// slot.
//
// A LOAD or STORE may be parked in the slot. While it is parked, younger
// non-memory ops may overtake it. The swap budget and the hold timeout limit
// this, so the parked op cannot starve.
//
// Ports:
//   clk_i, rst_ni            - clock and asynchronous active-low reset
//   flush_i                  - pipeline flush. It returns the controller to IDLE.
//   debug_req_i              - suspends reordering and forces the slot to drain
//   in_valid_i/in_fu_i/in_is_ctrl_flow_i/in_ack_i - incoming instruction
//   buf_valid_i/buf_fu_i     - occupancy of the reorder slot and its unit
//   lsu_ready_i              - the LSU can take an op
//                              (while it can, swapping is pointless)
//   hazard_i                 - register dependency between the incoming op
//                              and the slot entry
//   swap_en_o                - the incoming op may bypass the slot this cycle
//   fill_en_o                - a memory op may be parked in the slot
//   drain_o                  - the slot must be emptied
//   swap_cnt_o/stall_cnt_o/timeout_cnt_o - saturating performance counters
//
// Build option: define REORDER_PERF_CNT_EN to implement the three
// performance counters. Without it, the counter outputs are tied to zero.
// The FSM behaviour is the same in both builds.
module reorder_ctrl
  import reorder_pkg::*;
#(
  parameter int unsigned MAX_SWAPS = 4,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             debug_req_i,
  input  logic             in_valid_i,
  input  logic [FU_W-1:0]  in_fu_i,
  input  logic             in_is_ctrl_flow_i,
  input  logic             in_ack_i,
  input  logic             buf_valid_i,
  input  logic [FU_W-1:0]  buf_fu_i,
  input  logic             lsu_ready_i,
  input  logic             hazard_i,
  output logic             swap_en_o,
  output logic             fill_en_o,
  output logic             drain_o,
  output logic [CNT_W-1:0] swap_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam int unsigned SWAP_W = 4;  // holds MAX_SWAPS up to 15
  localparam int unsigned HOLD_W = 8;  // holds MAX_HOLD up to 255

  reorder_state_e    state_q, state_d;
  logic [SWAP_W-1:0] swaps_q, swaps_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic in_mem, in_barrier, buf_mem;
  logic swap_ok, timeout;

  assign in_mem     = is_mem_op(fu_t'(in_fu_i));
  assign in_barrier = is_barrier(fu_t'(in_fu_i), in_is_ctrl_flow_i);
  assign buf_mem    = is_mem_op(fu_t'(buf_fu_i));

  // Swapping only helps while the LSU is busy. Debug suspends all reordering.
  assign swap_ok = in_valid_i && !in_mem && !in_barrier && !lsu_ready_i &&
                   !hazard_i && !debug_req_i &&
                   (swaps_q < SWAP_W'(MAX_SWAPS));

  // The timeout is judged on the incremented hold count. A memory op is
  // therefore parked for at most MAX_HOLD-1 HOLD cycles.
  assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 2));

  always_comb begin
    state_d   = state_q;
    swaps_d   = swaps_q;
    hold_d    = hold_q;
    swap_en_o = 1'b0;
    fill_en_o = 1'b0;
    drain_o   = 1'b0;

    case (state_q)
      IDLE: begin
        fill_en_o = !debug_req_i;
        if (buf_valid_i) begin
          state_d = buf_mem ? HOLD : DRAIN;
        end
      end
      HOLD: begin
        swap_en_o = swap_ok;
        swaps_d   = swaps_q + SWAP_W'(swap_ok && in_ack_i);
        hold_d    = hold_q + 1'b1;
        // If the slot has emptied there is nothing to drain, so this check
        // takes priority over the DRAIN triggers.
        if (!buf_valid_i) begin
          state_d = IDLE;
        end else if ((swaps_d == SWAP_W'(MAX_SWAPS)) || timeout ||
                     (in_valid_i && in_barrier) || debug_req_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_o = 1'b1;
        if (!buf_valid_i && !debug_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      swaps_d = '0;
      hold_d  = '0;
    end

    // A flush overrides the next state. This cycle's outputs above still
    // follow the current state.
    if (flush_i) begin
      state_d = IDLE;
      swaps_d = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      swaps_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      swaps_q <= swaps_d;
      hold_q  <= hold_d;
    end
  end

`ifdef REORDER_PERF_CNT_EN
  // Events: [0] a swap is taken, [1] a HOLD cycle stalled on the LSU,
  // [2] a hold timeout occurs.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign cnt_inc[0] = swap_en_o && in_ack_i;
  assign cnt_inc[1] = (state_q == HOLD) && !lsu_ready_i && !swap_en_o;
  assign cnt_inc[2] = (state_q == HOLD) && buf_valid_i && timeout;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf_cnt
    reorder_perf_cnt #(
      .CNT_W(CNT_W)
    ) i_perf_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (cnt_inc[gi]),
      .cnt_o (cnt_val[gi])
    );
  end

  assign swap_cnt_o    = cnt_val[0];
  assign stall_cnt_o   = cnt_val[1];
  assign timeout_cnt_o = cnt_val[2];
`else
  assign swap_cnt_o    = '0;
  assign stall_cnt_o   = '0;
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reorder_ctrl.sv
// tb_reorder_ctrl: self-checking bench for reorder_ctrl.
// A behavioural model of the slot (parked / draining, swap and hold tallies,
// event counts) predicts the permission outputs and counters every cycle.
// Directed scenarios are followed by randomized traffic.
module tb_reorder_ctrl;

  localparam int MAX_SWAPS = 4;
  localparam int MAX_HOLD  = 16;
  localparam int CNT_W     = 6;   // narrow, so that saturation is reachable
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef REORDER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] F_NONE  = 4'd0;
  localparam logic [3:0] F_LOAD  = 4'd1;
  localparam logic [3:0] F_STORE = 4'd2;
  localparam logic [3:0] F_ALU   = 4'd3;
  localparam logic [3:0] F_BR    = 4'd4;
  localparam logic [3:0] F_MULT  = 4'd5;
  localparam logic [3:0] F_CSR   = 4'd6;

  logic clk = 1'b0;
  logic rst_ni, flush, debug, in_valid, in_ctrl, in_ack, buf_valid, lsu_ready, hazard;
  logic [3:0] in_fu, buf_fu;
  logic swap_en, fill_en, drain;
  logic [CNT_W-1:0] swap_cnt, stall_cnt, timeout_cnt;

  reorder_ctrl #(
    .MAX_SWAPS(MAX_SWAPS),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush),
    .debug_req_i      (debug),
    .in_valid_i       (in_valid),
    .in_fu_i          (in_fu),
    .in_is_ctrl_flow_i(in_ctrl),
    .in_ack_i         (in_ack),
    .buf_valid_i      (buf_valid),
    .buf_fu_i         (buf_fu),
    .lsu_ready_i      (lsu_ready),
    .hazard_i         (hazard),
    .swap_en_o        (swap_en),
    .fill_en_o        (fill_en),
    .drain_o          (drain),
    .swap_cnt_o       (swap_cnt),
    .stall_cnt_o      (stall_cnt),
    .timeout_cnt_o    (timeout_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model
  bit m_parked, m_drain;
  int m_swaps, m_held;
  int m_swap_cnt, m_stall_cnt, m_to_cnt;
  bit obs_swap, obs_fill, obs_drain;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic bit tb_mem(input logic [3:0] f);
    return (f == F_LOAD) || (f == F_STORE);
  endfunction

  function automatic bit tb_bar(input logic [3:0] f, input logic c);
    return c || (f == F_BR) || (f == F_CSR);
  endfunction

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Check one cycle against the model, then advance the model and the clock.
  task automatic run_cycle(input string tag);
    bit e_swap, e_fill, idle;
    int ns, nh;
    #3;
    idle   = !m_parked && !m_drain;
    e_swap = m_parked && in_valid && !tb_mem(in_fu) && !tb_bar(in_fu, in_ctrl) &&
             !lsu_ready && !hazard && !debug && (m_swaps < MAX_SWAPS);
    e_fill = idle && !debug;
    obs_swap = swap_en; obs_fill = fill_en; obs_drain = drain;
    check_val({tag, ".swap_en"}, swap_en, e_swap);
    check_val({tag, ".fill_en"}, fill_en, e_fill);
    check_val({tag, ".drain"},   drain,   m_drain);
    check_val({tag, ".swap_cnt"},    swap_cnt,    PERF ? m_swap_cnt  : 0);
    check_val({tag, ".stall_cnt"},   stall_cnt,   PERF ? m_stall_cnt : 0);
    check_val({tag, ".timeout_cnt"}, timeout_cnt, PERF ? m_to_cnt    : 0);

    if (rst_ni) begin
      if (e_swap && in_ack) m_swap_cnt = sat(m_swap_cnt);
      if (m_parked && !lsu_ready && !e_swap) m_stall_cnt = sat(m_stall_cnt);
      if (m_parked && buf_valid && (m_held + 1 == MAX_HOLD - 1)) m_to_cnt = sat(m_to_cnt);

      if (flush) begin
        m_parked = 0; m_drain = 0; m_swaps = 0; m_held = 0;
      end else if (idle) begin
        if (buf_valid) begin
          m_parked = tb_mem(buf_fu);
          m_drain  = !tb_mem(buf_fu);
        end
      end else if (m_parked) begin
        ns = m_swaps + ((e_swap && in_ack) ? 1 : 0);
        nh = m_held + 1;
        if (!buf_valid) begin
          m_parked = 0; m_swaps = 0; m_held = 0;
        end else if (ns == MAX_SWAPS || nh == MAX_HOLD - 1 ||
                     (in_valid && tb_bar(in_fu, in_ctrl)) || debug) begin
          m_parked = 0; m_drain = 1;
        end else begin
          m_swaps = ns; m_held = nh;
        end
      end else begin
        if (!buf_valid && !debug) begin
          m_drain = 0; m_swaps = 0; m_held = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet_inputs();
    flush = 0; debug = 0; in_valid = 0; in_ctrl = 0; in_ack = 0;
    in_fu = F_NONE; buf_valid = 0; buf_fu = F_NONE; lsu_ready = 1; hazard = 0;
  endtask

  initial begin
    int seen, first, t0, s0, r;
    logic [3:0] fu_tab [9];
    fu_tab = '{F_LOAD, F_STORE, F_ALU, F_ALU, F_ALU, F_MULT, F_BR, F_CSR, F_NONE};

    quiet_inputs();
    rst_ni = 0;
    m_parked = 0; m_drain = 0; m_swaps = 0; m_held = 0;
    m_swap_cnt = 0; m_stall_cnt = 0; m_to_cnt = 0;
    @(posedge clk); #1;
    run_cycle("in_reset");
    rst_ni = 1;
    run_cycle("reset_release");
    run_cycle("idle");
    $display("reset: fill_en=%0b swap_en=%0b drain=%0b", obs_fill, obs_swap, obs_drain);

    // Park a LOAD and let six ALU ops try to overtake it.
    buf_valid = 1; buf_fu = F_LOAD; lsu_ready = 0;
    run_cycle("park_load");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_fu = F_ALU; in_ack = 1;
      run_cycle("swap_burst");
      if (obs_swap) seen++;
    end
    check_val("swap_burst_total", seen, 4);
    check_val("swap_burst_drain", obs_drain, 1);
    in_valid = 0; in_ack = 0; buf_valid = 0;
    run_cycle("swap_empty");
    $display("swap burst: %0d swaps, swap_cnt=%0d", seen, swap_cnt);

    // Park a STORE with no incoming traffic until the hold timeout fires.
    t0 = int'(timeout_cnt); s0 = int'(stall_cnt);
    buf_valid = 1; buf_fu = F_STORE; lsu_ready = 0;
    run_cycle("park_store");
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      run_cycle("timeout");
      if (obs_drain && first == 0) first = k;
    end
    check_val("timeout_drain_cycle", first, 16);
    check_val("timeout_delta", int'(timeout_cnt) - t0, PERF ? 1 : 0);
    check_val("stall_delta", int'(stall_cnt) - s0, PERF ? 15 : 0);
    buf_valid = 0;
    run_cycle("timeout_empty");
    $display("timeout: drain on hold cycle %0d, timeout_cnt=%0d stall_cnt=%0d", first, timeout_cnt, stall_cnt);

    // A hazard blocks the swap. A branch then forces a drain.
    buf_valid = 1; buf_fu = F_LOAD; lsu_ready = 0;
    run_cycle("park_hazard");
    in_valid = 1; in_fu = F_ALU; in_ack = 1; hazard = 1;
    run_cycle("hazard");
    check_val("hazard_blocks_swap", obs_swap, 0);
    hazard = 0; in_fu = F_BR; in_ctrl = 1;
    run_cycle("branch");
    in_valid = 0; in_ctrl = 0; in_ack = 0;
    run_cycle("after_branch");
    check_val("branch_drains", obs_drain, 1);
    $display("hazard/branch: swap_en=0 then drain=%0b", obs_drain);

    // A flush in DRAIN with the slot still full returns to IDLE.
    s0 = int'(swap_cnt);
    flush = 1;
    run_cycle("flush");
    flush = 0;
    run_cycle("post_flush");
    check_val("flush_idle_fill", obs_fill, 1);
    check_val("flush_idle_drain", obs_drain, 0);
    check_val("flush_keeps_cnt", int'(swap_cnt), s0);
    // A fresh park after the flush starts with a full swap budget.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_fu = F_MULT; in_ack = 1;
      run_cycle("post_flush_swap");
    end
    in_valid = 0; in_ack = 0; buf_valid = 0;
    run_cycle("post_flush_empty");
    run_cycle("post_flush_idle");
    $display("flush: IDLE next cycle, swap_cnt retained=%0d", swap_cnt);

    // A debug request in HOLD drains the slot and holds DRAIN while the request is active.
    buf_valid = 1; buf_fu = F_LOAD; lsu_ready = 0;
    run_cycle("park_debug");
    debug = 1;
    for (int i = 0; i < 4; i++) run_cycle("debug_full");
    buf_valid = 0;
    for (int i = 0; i < 2; i++) run_cycle("debug_empty");
    check_val("debug_holds_drain", obs_drain, 1);
    check_val("debug_no_fill", obs_fill, 0);
    debug = 0;
    run_cycle("debug_release");
    run_cycle("debug_idle");
    check_val("debug_back_idle", obs_fill, 1);
    $display("debug: drain held until release, fill_en=%0b afterwards", obs_fill);

    // Randomized traffic
    quiet_inputs();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) buf_valid = ~buf_valid;
      if ($urandom_range(29) == 0) debug = ~debug;
      r = $urandom_range(8);
      buf_fu    = ($urandom_range(3) == 0) ? F_ALU : (($urandom_range(1) == 0) ? F_LOAD : F_STORE);
      flush     = ($urandom_range(39) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_fu     = fu_tab[r];
      in_ctrl   = ($urandom_range(15) == 0);
      in_ack    = ($urandom_range(3) != 0);
      lsu_ready = ($urandom_range(3) == 0);
      hazard    = ($urandom_range(5) == 0);
      run_cycle("random");
      if (n % 500 == 499)
        $display("random: %0d cycles, swap_cnt=%0d stall_cnt=%0d timeout_cnt=%0d",
                 n + 1, swap_cnt, stall_cnt, timeout_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_ctrl.md
# reorder_ctrl

Sequencing controller for the issue-stage memory-op reorder slot between the issue queue and the scoreboard. Decides each cycle whether a younger non-memory instruction may overtake a buffered LOAD/STORE (swap), whether a memory op may be parked in the slot (fill), and when the slot must be force-drained. Bounds reordering with a swap budget and a hold timeout so a parked memory op cannot starve. The datapath slot instantiates this block and obeys its three permission outputs.

## Interface
- MAX_SWAPS, 4: max younger instructions allowed to overtake one parked memory op; range 1..15.
- MAX_HOLD, 16: max cycles a memory op may stay parked; range 2..255.
- CNT_W, 32: width of performance counters.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush.
- debug_req_i  in  1  debug request; reordering suspended while high.
- in_valid_i  in  1  incoming instruction valid.
- in_fu_i  in  ariane_pkg::fu_t  incoming functional unit.
- in_is_ctrl_flow_i  in  1  incoming instruction is control flow.
- in_ack_i  in  1  incoming instruction accepted this cycle.
- buf_valid_i  in  1  reorder slot occupied.
- buf_fu_i  in  ariane_pkg::fu_t  functional unit of the slot entry.
- lsu_ready_i  in  1  LSU can accept an op.
- hazard_i  in  1  register dependency between incoming and slot entry (datapath-computed).
- swap_en_o  out  1  incoming may bypass the slot this cycle.
- fill_en_o  out  1  a memory op may be parked in the slot.
- drain_o  out  1  slot must be emptied; no fill, no swap.
- swap_cnt_o, stall_cnt_o, timeout_cnt_o  out  CNT_W each  performance counters.

## Operation
- mem_op = fu is LOAD or STORE; barrier = in_is_ctrl_flow_i or in_fu_i is CTRL_FLOW or CSR.
- States: IDLE, HOLD, DRAIN.
- IDLE: fill_en_o=1 unless debug_req_i; on buf_valid_i & mem_op(buf_fu_i) -> HOLD; on buf_valid_i & !mem_op -> DRAIN.
- HOLD: swap_en_o = in_valid_i & !mem_op(in_fu_i) & !barrier & !lsu_ready_i & !hazard_i & swaps_q < MAX_SWAPS. hold_q increments every cycle; swaps_q increments on swap_en_o & in_ack_i.
- HOLD -> DRAIN when next swaps_q reaches MAX_SWAPS, or hold_q reaches MAX_HOLD-1 (timeout, timeout_cnt += 1), or (in_valid_i & barrier), or debug_req_i. HOLD -> IDLE when !buf_valid_i.
- DRAIN: drain_o=1, swap_en_o=fill_en_o=0; -> IDLE when !buf_valid_i & !debug_req_i.
- Entering IDLE clears swaps_q and hold_q.
- flush_i: next state IDLE, swaps_q=hold_q=0, outputs of flush cycle still computed from current state; perf counters not cleared.
- stall_cnt increments each cycle in HOLD with !lsu_ready_i & !swap_en_o.
- Perf counters saturate at all-ones.

## Timing
- Reset: state IDLE, swaps_q=hold_q=0, all counters 0; swap_en_o=0, drain_o=0, fill_en_o=1.
- swap_en_o, fill_en_o, drain_o combinational from state and same-cycle inputs; state/counters update on clk_i rising edge.
- Transitions take effect next cycle; decision inputs sampled in the same cycle as their effect.
- Simultaneous swap completion and timeout: swap counted, DRAIN entered.
- Simultaneous flush and debug_req_i: flush wins (IDLE); DRAIN re-entered next cycle if buffer refills.

## Configuration
- REORDER_PERF_CNT_EN defined: three counters implemented and driven.
- Undefined: counters removed, swap_cnt_o/stall_cnt_o/timeout_cnt_o tied to 0; FSM behaviour identical.

## Structure
- reorder_pkg: reorder_state_e enum (IDLE, HOLD, DRAIN), is_mem_op(fu_t) and is_barrier(fu_t, ctrl_flow) functions.
- One sub-module: reorder_perf_cnt, a CNT_W saturating counter with inc_i/clear-on-reset, instantiated three times under the macro.

## Test plan
- Reset release with buf_valid_i=0 -> state IDLE, fill_en_o=1, swap_en_o=0, drain_o=0.
- Park LOAD, lsu_ready_i=0, feed 6 ALU ops acked, no hazard -> swap_en_o high for exactly 4, DRAIN entered after 4th, swap_cnt_o=4.
- Park STORE, lsu_ready_i=0, no incoming for 16 cycles -> DRAIN on cycle 16, timeout_cnt_o=1, stall_cnt_o=15.
- HOLD with ALU op and hazard_i=1 -> swap_en_o=0; incoming branch -> DRAIN next cycle.
- flush_i in DRAIN with buf_valid_i=1 -> IDLE next cycle, swaps_q/hold_q=0, counters retained.
- debug_req_i high in HOLD -> DRAIN, stays DRAIN until debug_req_i low and slot empty, fill_en_o=0 throughout.
